// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and word-write memory bus of the image loader.
// slave: loader side; master: stream source / memory model side.
interface imem_stream_loader_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wen;

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_addr, mem_wdata, mem_wen
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_addr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/imem_stream_loader.sv
// Loads a program image from a byte stream into memory, holding the CPU in reset.
// Ports: clk, rst_n (async low); bus (stream in / word writes out); start re-arms
// from DONE/ERR; cpu_rst_n, done, err, words_cnt report load status.
module imem_stream_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MEM_SIZE_WORDS = 1024,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_stream_loader_if.slave  bus,
    input  logic                 start,
    output logic                 cpu_rst_n,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          words_cnt
);
    localparam logic [31:0] MAX_N    = 32'(MEM_SIZE_WORDS);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_buf;
    logic [31:0] r_n;
    logic [31:0] r_tmo;
    logic        r_s_ready;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wen;
    logic        r_cpu_rst_n;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_words;

    logic        w_acc;
    logic [31:0] w_shift;
    logic [15:0] w_words_nxt;

    // Bytes arrive LSB first, so each new byte enters at the top.
    assign w_acc       = bus.s_valid && r_s_ready;
    assign w_shift     = {bus.s_data, r_buf[31:8]};
    assign w_words_nxt = r_words + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HDR;
            r_idx       <= 2'd0;
            r_buf       <= 32'd0;
            r_n         <= 32'd0;
            r_tmo       <= 32'd0;
            r_s_ready   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wen   <= 4'b0000;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= 16'd0;
        end else begin
            r_mem_wen <= 4'b0000;
            case (r_state)
                S_HDR: begin
                    r_s_ready <= 1'b1;
                    if (w_acc) begin
                        r_tmo <= 32'd0;
                        r_buf <= w_shift;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_n <= w_shift;
                            if (w_shift == 32'd0) begin
                                r_state     <= S_DONE;
                                r_s_ready   <= 1'b0;
                                r_done      <= 1'b1;
                                r_cpu_rst_n <= 1'b1;
                            end else if (w_shift > MAX_N) begin
                                r_state   <= S_ERR;
                                r_s_ready <= 1'b0;
                                r_err     <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end else if (r_idx != 2'd0) begin
                        // Timeout only runs once the frame has started.
                        if (r_tmo == TMO_LAST) begin
                            r_state   <= S_ERR;
                            r_s_ready <= 1'b0;
                            r_err     <= 1'b1;
                        end else begin
                            r_tmo <= r_tmo + 32'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_tmo <= 32'd0;
                        r_buf <= w_shift;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state     <= S_WRITE;
                            r_s_ready   <= 1'b0;
                            r_mem_wen   <= 4'b1111;
                            r_mem_wdata <= w_shift;
                            r_mem_addr  <= BASE_ADDR
                                         + {14'd0, r_words, 2'b00};
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_state   <= S_ERR;
                        r_s_ready <= 1'b0;
                        r_err     <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                S_WRITE: begin
                    r_words <= w_words_nxt;
                    if ({16'd0, w_words_nxt} == r_n) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_cpu_rst_n <= 1'b1;
                    end else begin
                        r_state   <= S_DATA;
                        r_s_ready <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        r_state     <= S_HDR;
                        r_s_ready   <= 1'b1;
                        r_cpu_rst_n <= 1'b0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_words     <= 16'd0;
                        r_idx       <= 2'd0;
                        r_tmo       <= 32'd0;
                    end
                end
                default: begin
                    r_state   <= S_ERR;
                    r_s_ready <= 1'b0;
                    r_err     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wen   = r_mem_wen;
    assign cpu_rst_n     = r_cpu_rst_n;
    assign done          = r_done;
    assign err           = r_err;
    assign words_cnt     = r_words;
endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized self-checking bench for imem_stream_loader.
// Frame images are built here and the expected write list is derived from them.
module tb_imem_stream_loader;
    localparam int TMO = 40;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cpu_rst_n;
    logic        done;
    logic        err;
    logic [15:0] words_cnt;

    imem_stream_loader_if bus();

    imem_stream_loader #(
        .BASE_ADDR(BASE),
        .MEM_SIZE_WORDS(1024),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .start(start),
        .cpu_rst_n(cpu_rst_n),
        .done(done),
        .err(err),
        .words_cnt(words_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] img[$];
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Capture every write strobe; a strobe must be a full word with the
    // stream stalled.
    always @(negedge clk) begin
        if (rst_n && bus.mem_wen != 4'b0000) begin
            got_a.push_back(bus.mem_addr);
            got_d.push_back(bus.mem_wdata);
            check("wen_full", 32'(bus.mem_wen), 32'hF);
            check("ready_in_write", 32'(bus.s_ready), 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        if (rnd) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++) begin
                bus.s_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        n = 0;
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] n, input bit rnd);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], rnd);
    endtask

    task automatic send_frame(input bit rnd);
        logic [31:0] w;
        got_a.delete();
        got_d.delete();
        send_hdr(32'(img.size()), rnd);
        foreach (img[i]) begin
            w = img[i];
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], rnd);
        end
    endtask

    task automatic expect_done(input string tag);
        int k;
        k = 0;
        while (!(done || err) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_nwr"}, 32'(got_a.size()), 32'(img.size()));
        for (int i = 0; i < img.size() && i < got_a.size(); i++) begin
            check({tag, "_addr"}, got_a[i], BASE + 32'(4 * i));
            check({tag, "_data"}, got_d[i], img[i]);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cpu"}, 32'(cpu_rst_n), 32'd1);
        check({tag, "_cnt"}, 32'(words_cnt), 32'(img.size()));
        check({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_st_done"}, 32'(done), 32'd0);
        check({tag, "_st_err"}, 32'(err), 32'd0);
        check({tag, "_st_cpu"}, 32'(cpu_rst_n), 32'd0);
        check({tag, "_st_cnt"}, 32'(words_cnt), 32'd0);
        check({tag, "_st_ready"}, 32'(bus.s_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
        check({tag, "_wen"}, 32'(bus.mem_wen), 32'd0);
        check({tag, "_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_cpu"}, 32'(cpu_rst_n), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cnt"}, 32'(words_cnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_up", 32'(bus.s_ready), 32'd1);

        // Directed three-instruction image.
        img = '{32'h0030_0513, 32'h01A0_0593, 32'h00B5_0633};
        send_frame(1'b0);
        expect_done("t1");
        @(negedge clk);
        check("t1_hold_ready", 32'(bus.s_ready), 32'd0);
        pulse_start("t1");

        // Empty image releases the CPU straight after the header.
        got_a.delete();
        got_d.delete();
        send_hdr(32'd0, 1'b0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_cpu", 32'(cpu_rst_n), 32'd1);
        check("t2_nwr", 32'(got_a.size()), 32'd0);
        pulse_start("t2");

        // Oversized image count.
        send_hdr(32'd1025, 1'b0);
        check("t3_err", 32'(err), 32'd1);
        check("t3_ready", 32'(bus.s_ready), 32'd0);
        check("t3_cpu", 32'(cpu_rst_n), 32'd0);
        check("t3_nwr", 32'(got_a.size()), 32'd0);
        pulse_start("t3");

        // Largest legal count is accepted (enters data phase, no error).
        send_hdr(32'd1024, 1'b0);
        check("t3b_err", 32'(err), 32'd0);
        check("t3b_ready", 32'(bus.s_ready), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stall after one word of a two-word frame: error after exactly
        // TMO idle cycles spent waiting in the data phase.
        got_a.delete();
        got_d.delete();
        send_hdr(32'd2, 1'b0);
        for (int b = 0; b < 4; b++) send_byte(8'hA0 + 8'(b), 1'b0);
        repeat (TMO) @(negedge clk);
        check("t4_err_early", 32'(err), 32'd0);
        @(negedge clk);
        check("t4_err", 32'(err), 32'd1);
        check("t4_nwr", 32'(got_a.size()), 32'd1);
        if (got_d.size() > 0) check("t4_data", got_d[0], 32'hA3A2_A1A0);
        check("t4_cpu", 32'(cpu_rst_n), 32'd0);
        pulse_start("t4");

        // Randomized frames with random byte gaps.
        for (int f = 0; f < 6; f++) begin
            int nw;
            nw = (f == 0) ? 2 : $urandom_range(1, 5);
            img.delete();
            for (int i = 0; i < nw; i++) img.push_back($urandom);
            send_frame(1'b1);
            expect_done($sformatf("rnd%0d", f));
            pulse_start($sformatf("rnd%0d", f));
        end

        // Asynchronous reset in the middle of a data word.
        img = '{$urandom};
        send_hdr(32'd1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(1'b1);
        expect_done("t6_reload");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
